// File: rtl/flash_sample_fetch.sv
// Fetches one 32-bit song word per handshake from the flash Avalon-MM slave and
// holds it for the audio output stage, stepping the word address with wrap-around.
module flash_sample_fetch #(
  parameter int                ADDR_W     = 23,
  parameter logic [ADDR_W-1:0] START_ADDR = 23'h000000,
  parameter logic [ADDR_W-1:0] END_ADDR   = 23'h07FFFF
) (
  input  logic              clk50,
  input  logic              reset,
  input  logic              play,
  input  logic              direction,
  input  logic              restart,
  input  logic              change,
  input  logic              flash_mem_waitrequest,
  input  logic              flash_mem_readdatavalid,
  input  logic [31:0]       flash_mem_readdata,
  output logic              flash_mem_read,
  output logic [ADDR_W-1:0] flash_mem_address,
  output logic [3:0]        flash_mem_byteenable,
  output logic [31:0]       audio_data_in,
  output logic              finished
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_READY = 3'd3;
  localparam logic [2:0] S_STEP  = 3'd4;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [ADDR_W-1:0] addr;
  logic              restart_pend;
  logic              restart_dir;

  function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a,
                                                  input logic fwd);
    if (fwd) return (a == END_ADDR) ? START_ADDR : a + 1'b1;
    return (a == START_ADDR) ? END_ADDR : a - 1'b1;
  endfunction

  function automatic logic [ADDR_W-1:0] restart_addr(input logic fwd);
    return fwd ? START_ADDR : END_ADDR;
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (play) state_nxt = S_REQ;
      S_REQ:   if (!flash_mem_waitrequest) state_nxt = S_WAIT;
      S_WAIT:  if (flash_mem_readdatavalid) state_nxt = S_READY;
      // restart outranks change: the held word is refetched from the new address
      S_READY: begin
        if (restart)     state_nxt = play ? S_REQ : S_IDLE;
        else if (change) state_nxt = S_STEP;
      end
      S_STEP:  state_nxt = play ? S_REQ : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      addr           <= START_ADDR;
      restart_pend   <= 1'b0;
      restart_dir    <= 1'b1;
      flash_mem_read <= 1'b0;
      audio_data_in  <= 32'h0;
      finished       <= 1'b0;
    end else begin
      state          <= state_nxt;
      flash_mem_read <= (state_nxt == S_REQ);
      finished       <= (state_nxt == S_READY);
      if (state == S_WAIT && flash_mem_readdatavalid)
        audio_data_in <= flash_mem_readdata;
      // a restart during a bus transaction is parked until STEP so the address stays put
      case (state)
        S_IDLE, S_READY: begin
          if (restart) begin
            addr         <= restart_addr(direction);
            restart_pend <= 1'b0;
          end
        end
        S_REQ, S_WAIT: begin
          if (restart) begin
            restart_pend <= 1'b1;
            restart_dir  <= direction;
          end
        end
        S_STEP: begin
          if (restart)           addr <= restart_addr(direction);
          else if (restart_pend) addr <= restart_addr(restart_dir);
          else                   addr <= step_addr(addr, direction);
          restart_pend <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign flash_mem_address    = addr;
  assign flash_mem_byteenable = 4'b1111;

endmodule
